dbus_sram_responder: RTL and testbench
======================================

// Module: dbus_sram_responder
// PURPOSE
//  Slave end of the data bus: accepts dbus_req_t from the memory stage and returns dbus_resp_t.
//  Backed by a word-addressed 64-bit RAM with byte-strobe writes and a programmable response latency.
//  Used as the data-memory model in simulation and as the reference responder for memory-stage verification.
//  Returns whole aligned doublewords; lane extraction and sign extension stay in the requester.
// PARAMETERS
//  DEPTH    512  number of 64-bit words; power of two
//  LATENCY  2    extra wait cycles between accept and data_ok (0..15)
// PORTS
//  clk        in   1    clock; the only clock
//  reset      in   1    synchronous, active-high
//  dreq       in   dbus_req_t   {valid, addr[63:0], size (msize_t), strobe[7:0], data[63:0]}
//  dresp      out  dbus_resp_t  {addr_ok, data_ok, data[63:0]}
//  busy       out  1    a transaction has been accepted and data_ok is not yet sent
// BEHAVIOUR
//  Reset and clocking
//   - Clock clk; reset is synchronous and active-high.
//   - On reset: state=IDLE, cnt=0, dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0, busy=0.
//   - RAM contents are not cleared by reset. They are zero at time 0 in simulation.
//  FSM states: IDLE, WAIT, RESP.
//   - IDLE: dresp.addr_ok = dreq.valid (combinational; the only cycle addr_ok is high).
//       On valid, at the clock edge: capture addr, strobe and data into req_q.
//       Then cnt<=LATENCY, and state<=(LATENCY==0 ? RESP : WAIT).
//   - WAIT: cnt decrements once per cycle. Move to RESP on the edge where cnt==1.
//   - RESP: dresp.data_ok=1 for exactly this one cycle. state<=IDLE.
//       A new request can be accepted in the next cycle.
//   - Latency: accept in cycle T gives data_ok in cycle T+1+LATENCY. No back-to-back accept in the RESP cycle.
//  Address
//   - idx = req_q.addr[3 +: $clog2(DEPTH)]. Bits [2:0] and bits above the index are ignored.
//   - Out-of-range addresses wrap modulo DEPTH.
//  Reads (strobe==0)
//   - The RAM word is read and registered on entry to RESP.
//   - dresp.data is valid only while data_ok=1; it is 0 in every other cycle.
//  Writes (strobe!=0)
//   - For each i, byte i of ram[idx] <= req_q.data[8i+7:8i] if strobe[i]==1.
//   - The write commits on the edge entering RESP. dresp.data=0 during the write data_ok.
//  Ordering and hazards
//   - Requests are strictly in order; at most 1 outstanding.
//   - A read after a write to the same word returns the written bytes.
//  Stability
//   - The requester holds dreq stable until data_ok. The responder uses only req_q after accept,
//     so changes to dreq in WAIT/RESP are ignored.
//  busy = (state!=IDLE).
//  Reset mid-transaction
//   - The FSM returns to IDLE and the pending response is dropped.
//   - A write whose commit edge has not occurred is discarded.
//   - No data_ok is emitted in the cycle after reset.
//  dreq.valid=0 in IDLE: all outputs stay 0 and state is unchanged.
// TESTING
//  1. Reset, LATENCY=2, read addr 0x40 -> addr_ok in cycle T, data_ok only at T+3, data=0.
//  2. Write addr 0x48, strobe 0xFF, data 0x1122334455667788, then read 0x48 -> data 0x1122334455667788.
//  3. Write strobe 0x0F, data 0xAAAAAAAA_BBBBBBBB over 0x1122334455667788, then read
//     -> 0x11223344BBBBBBBB; addr 0x4C reads the same word.
//  4. LATENCY=0: back-to-back reads -> data_ok at T+1; next addr_ok no earlier than T+2; data_ok never high 2 cycles.
//  5. Change dreq.addr/data during WAIT -> response and RAM update use the values captured at accept.
//  6. Assert reset in WAIT of a write to 0x80 -> no data_ok; a later read of 0x80 returns the old value;
//     addr 0x80+8*DEPTH aliases 0x80.

Source files
------------

// File: rtl/dbus_sram_responder.sv
// Data-bus slave backed by a word-addressed 64-bit RAM with byte strobes.
// Responds to one request at a time after a fixed, programmable latency.
package dbus_pkg;
  typedef enum logic [2:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    msize_t      size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;
endpackage

module dbus_sram_responder
  import dbus_pkg::*;
#(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output logic       busy
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   reqIdx_q, reqIdx_d;
  logic [7:0]      reqStrobe_q, reqStrobe_d;
  logic [63:0]     reqData_q, reqData_d;
  logic [63:0]     rdata_q, rdata_d;

  logic [63:0]     mem [DEPTH];

  logic            enterResp;
  logic            writeEn;
  logic [AW-1:0]   curIdx;
  logic [7:0]      curStrobe;
  logic [63:0]     curData;

  logic            unusedBits;
  assign unusedBits = ^{dreq.addr[63:3+AW], dreq.addr[2:0], dreq.size};

  // With zero latency RESP is entered on the accept edge, so the live request is used there
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    reqIdx_d    = reqIdx_q;
    reqStrobe_d = reqStrobe_q;
    reqData_d   = reqData_q;
    rdata_d     = rdata_q;
    enterResp   = 1'b0;
    writeEn     = 1'b0;
    curIdx      = reqIdx_q;
    curStrobe   = reqStrobe_q;
    curData     = reqData_q;

    case (state_q)
      IDLE: begin
        if (dreq.valid) begin
          reqIdx_d    = dreq.addr[3 +: AW];
          reqStrobe_d = dreq.strobe;
          reqData_d   = dreq.data;
          cnt_d       = 4'(LATENCY);
          if (LATENCY == 0) begin
            state_d   = RESP;
            enterResp = 1'b1;
            curIdx    = dreq.addr[3 +: AW];
            curStrobe = dreq.strobe;
            curData   = dreq.data;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d   = RESP;
          enterResp = 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (enterResp) begin
      writeEn = (curStrobe != 8'd0) && !reset;
      rdata_d = (curStrobe != 8'd0) ? 64'd0 : mem[curIdx];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      reqIdx_q    <= '0;
      reqStrobe_q <= 8'd0;
      reqData_q   <= 64'd0;
      rdata_q     <= 64'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      reqIdx_q    <= reqIdx_d;
      reqStrobe_q <= reqStrobe_d;
      reqData_q   <= reqData_d;
      rdata_q     <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (writeEn) begin
      for (int i = 0; i < 8; i++) begin
        if (curStrobe[i]) mem[curIdx][8*i +: 8] <= curData[8*i +: 8];
      end
    end
  end

  assign dresp.addr_ok = (state_q == IDLE) && dreq.valid && !reset;
  assign dresp.data_ok = (state_q == RESP);
  assign dresp.data    = (state_q == RESP) ? rdata_q : 64'd0;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Randomised scoreboard bench for dbus_sram_responder: two instances, LATENCY=2 and LATENCY=0.
// Expected read data comes from a plain array model of memory updated as responses retire.
module tb_dbus_sram_responder;
  import dbus_pkg::*;

  localparam int DEPTH = 512;

  typedef struct {
    int          idx;
    logic [7:0]  strb;
    logic [63:0] data;
    int          due;
    bit          hasConst;
    logic [63:0] constVal;
  } txn_t;

  logic       clk;
  logic       reset;
  dbus_req_t  dreq [2];
  dbus_resp_t dresp [2];
  logic       busy [2];

  int          checks = 0;
  int          errors = 0;
  int          cycle  = 0;
  txn_t        sbq [2][$];
  logic [63:0] model [2][DEPTH];

  dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(2)) u_dutLat2 (
    .clk(clk), .reset(reset), .dreq(dreq[0]), .dresp(dresp[0]), .busy(busy[0]));

  dbus_sram_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_dutLat0 (
    .clk(clk), .reset(reset), .dreq(dreq[1]), .dresp(dresp[1]), .busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle++;

  function automatic int latOf(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string name, input int d, input logic [63:0] act,
                             input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: got %h expected %h", name, d, cycle, act, exp);
    end
  endtask

  // Monitor: retire responses against the array model whenever data_ok is seen
  task automatic monitorDut(input int d);
    txn_t        t;
    logic [63:0] exp;
    checkOutput("busy", d, 64'(busy[d]), 64'(sbq[d].size() != 0));
    if (dresp[d].data_ok) begin
      if (sbq[d].size() == 0) begin
        checkOutput("unexpected_data_ok", d, 64'd1, 64'd0);
      end else begin
        t = sbq[d].pop_front();
        checkOutput("latency", d, 64'(cycle), 64'(t.due));
        if (t.strb == 8'd0) begin
          exp = model[d][t.idx];
        end else begin
          for (int i = 0; i < 8; i++)
            if (t.strb[i]) model[d][t.idx][8*i +: 8] = t.data[8*i +: 8];
          exp = 64'd0;
        end
        checkOutput("resp_data", d, dresp[d].data, exp);
        if (t.hasConst) checkOutput("directed_data", d, dresp[d].data, t.constVal);
      end
    end else begin
      checkOutput("idle_data", d, dresp[d].data, 64'd0);
    end
  endtask

  always @(negedge clk) begin
    monitorDut(0);
    monitorDut(1);
  end

  task automatic applyStimulus(input int d, input logic [63:0] addr, input logic [7:0] strb,
                               input logic [63:0] data, input bit hold, input bit hasConst,
                               input logic [63:0] constVal);
    txn_t t;
    int   waited;
    @(negedge clk);
    dreq[d] = '{valid: 1'b1, addr: addr, size: MSIZE8, strobe: strb, data: data};
    #1;
    checkOutput("addr_ok", d, 64'(dresp[d].addr_ok), 64'd1);
    t.idx      = int'((addr >> 3) % DEPTH);
    t.strb     = strb;
    t.data     = data;
    t.due      = cycle + 1 + latOf(d);
    t.hasConst = hasConst;
    t.constVal = constVal;
    sbq[d].push_back(t);
    @(posedge clk);
    #1;
    if (hold) begin
      while (cycle <= t.due) begin
        dreq[d].addr   = {$urandom, $urandom};
        dreq[d].data   = {$urandom, $urandom};
        dreq[d].strobe = 8'($urandom);
        #1;
        checkOutput("no_accept_while_busy", d, 64'(dresp[d].addr_ok), 64'd0);
        @(posedge clk);
        #1;
      end
    end
    dreq[d].valid = 1'b0;
    waited = 0;
    while (sbq[d].size() != 0 && waited < 40) begin
      @(posedge clk);
      #1;
      waited++;
    end
    if (sbq[d].size() != 0) begin
      checkOutput("response_timeout", d, 64'd0, 64'd1);
      sbq[d].delete();
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [63:0] a;
    logic [63:0] wd;
    logic [7:0]  s;
    int          d;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < DEPTH; i++) model[k][i] = 64'd0;
    for (int k = 0; k < 2; k++) dreq[k] = '0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    dreq[0].valid = 1'b1;
    #1;
    for (int k = 0; k < 2; k++) begin
      checkOutput("reset_addr_ok", k, 64'(dresp[k].addr_ok), 64'd0);
      checkOutput("reset_data_ok", k, 64'(dresp[k].data_ok), 64'd0);
      checkOutput("reset_busy", k, 64'(busy[k]), 64'd0);
    end
    dreq[0].valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;

    applyStimulus(0, 64'h40, 8'h00, 64'd0, 1'b0, 1'b1, 64'd0);
    applyStimulus(0, 64'h48, 8'hFF, 64'h1122334455667788, 1'b0, 1'b0, 64'd0);
    applyStimulus(0, 64'h48, 8'h00, 64'd0, 1'b0, 1'b1, 64'h1122334455667788);
    applyStimulus(0, 64'h48, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b0, 1'b0, 64'd0);
    applyStimulus(0, 64'h48, 8'h00, 64'd0, 1'b0, 1'b1, 64'h11223344BBBBBBBB);
    applyStimulus(0, 64'h4C, 8'h00, 64'd0, 1'b0, 1'b1, 64'h11223344BBBBBBBB);

    applyStimulus(1, 64'h10, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b1, 1'b0, 64'd0);
    for (int i = 0; i < 4; i++)
      applyStimulus(1, 64'h10, 8'h00, 64'd0, 1'b1, 1'b1, 64'hDEADBEEF_CAFEF00D);

    applyStimulus(0, 64'h50, 8'hFF, 64'h0123456789ABCDEF, 1'b1, 1'b0, 64'd0);
    applyStimulus(0, 64'h50, 8'h00, 64'd0, 1'b1, 1'b1, 64'h0123456789ABCDEF);

    applyStimulus(0, 64'h80, 8'hFF, 64'h5555666677778888, 1'b0, 1'b0, 64'd0);
    begin
      txn_t t;
      @(negedge clk);
      dreq[0] = '{valid: 1'b1, addr: 64'h80, size: MSIZE8, strobe: 8'hFF,
                  data: 64'h9999AAAABBBBCCCC};
      #1;
      checkOutput("addr_ok", 0, 64'(dresp[0].addr_ok), 64'd1);
      t.idx = 16; t.strb = 8'hFF; t.data = 64'h9999AAAABBBBCCCC;
      t.due = cycle + 3; t.hasConst = 1'b0; t.constVal = 64'd0;
      sbq[0].push_back(t);
      @(posedge clk);
      #1;
      dreq[0].valid = 1'b0;
      @(negedge clk);
      #1;
      reset = 1'b1;
      sbq[0].delete();
      @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (6) @(posedge clk);
      #1;
    end
    applyStimulus(0, 64'h80, 8'h00, 64'd0, 1'b0, 1'b1, 64'h5555666677778888);
    applyStimulus(0, 64'h80 + 64'(8 * DEPTH), 8'h00, 64'd0, 1'b0, 1'b1, 64'h5555666677778888);

    for (int n = 0; n < 200; n++) begin
      d  = int'($urandom_range(0, 1));
      a  = {$urandom, $urandom};
      a[12:3] = 10'($urandom_range(0, 23));
      s  = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      wd = {$urandom, $urandom};
      applyStimulus(d, a, s, wd, 1'($urandom_range(0, 1)), 1'b0, 64'd0);
    end

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
